pll_freq_monitor: RTL and testbench
===================================

# pll_freq_monitor

Round-robin frequency monitor for PLL-generated clocks. Each monitored clock domain supplies a divide-by-2 toggle flop. This block, running on the boot/reference clock, synchronizes the toggles and counts their transitions over a fixed reference window per channel. It reports a count and a per-channel in-range flag, giving on-chip confirmation that each PLL output (CLK_OUT, DIV2..DIV4 of each PLL) is running at its programmed rate.

## Interface

Parameters:
- NUM_CH, 8: number of monitored channels (1..16).
- WINDOW_CYCLES, 1024: reference-clock cycles per measurement window (≥ 4).
- CNT_W, 16: width of the edge counter and thresholds.

Ports:
- clk  in  1  reference clock (boot clock); all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable; level-sensitive.
- meas_tgl  in  NUM_CH  toggle signals from monitored domains; asynchronous to clk.
- lo_thresh  in  CNT_W  inclusive lower bound for in-range.
- hi_thresh  in  CNT_W  inclusive upper bound for in-range.
- result_valid  out  1  one-cycle pulse, result fields valid.
- result_ch  out  $clog2(NUM_CH) (min 1)  channel of current result.
- result_cnt  out  CNT_W  transitions counted in window.
- in_range  out  NUM_CH  sticky-until-remeasured per-channel pass flag.
- busy  out  1  high in any state other than IDLE.

## Operation

- meas_tgl passes through a 2-FF synchronizer, then one delay flop. A transition is sync XOR delayed on the currently selected channel.
- States:
  - IDLE: if en=1, go to SETTLE.
  - SETTLE: 4 cycles. Flushes stale edge history after a channel switch. The counter is cleared; transitions are ignored.
  - COUNT: exactly WINDOW_CYCLES cycles. The counter increments on each detected transition and saturates at 2^CNT_W−1 with no wrap.
  - REPORT: 1 cycle.
    - result_valid=1; result_ch and result_cnt are driven.
    - in_range[ch] is updated to (lo_thresh ≤ cnt ≤ hi_thresh), using thresholds sampled in this cycle.
    - The channel advances as ch+1, wrapping NUM_CH−1→0.
    - Next state is SETTLE if en=1, else IDLE.
- en deasserted in SETTLE or COUNT: abort to IDLE next cycle. No result, in_range unchanged, channel not advanced.
- lo_thresh > hi_thresh: the flag is written 0.
- result_ch and result_cnt hold their last reported values between pulses.
- Valid measurement requires the monitored clock to run below clk/2 (toggle rate < clk/4 transitions per cycle… i.e. ≤1 transition per 2 clk cycles). Above that, counts alias and the value is unspecified, but the block must not hang.
- Reset values: state IDLE, channel 0, all outputs 0, counter 0, synchronizer flops 0.

## Timing

- en sampled high in IDLE at edge E0 gives the first result_valid at edge E0+WINDOW_CYCLES+5.
- With continuous en, the result period is WINDOW_CYCLES+5 cycles per channel and NUM_CH×(WINDOW_CYCLES+5) per full scan.
- in_range[ch] becomes visible the cycle after the REPORT edge, concurrently with result_valid.
- Input-to-count latency is 3 cycles (2 sync + 1 delay). SETTLE covers it.
- Reset asserted mid-window: immediate return to reset state; no partial result is emitted.

## Structure

- Package pll_freq_monitor_pkg:
  - state enum {IDLE, SETTLE, COUNT, REPORT};
  - constant SETTLE_CYCLES=4;
  - constant SYNC_STAGES=2.
- Sub-module sync_2ff: a parameterized-width vector synchronizer with async active-high reset. It is instantiated once for meas_tgl.
- The top level holds the FSM, window counter ($clog2(WINDOW_CYCLES+1) bits), edge counter, channel pointer and flag register.

## Test plan

- WINDOW_CYCLES=256, ch0 toggle changes every 4 clk cycles, thresholds 60..68, en held high → result_valid with result_ch=0, result_cnt=64±1, in_range[0]=1, at cycle 261 after en.
- Channels toggling every 2, 4, 8, 16 cycles, en held high for one scan → counts ≈128, 64, 32, 16, reported in channel order 0,1,2,3 with period 261 cycles; channel wraps from 7 to 0.
- CNT_W=6, toggle every 2 cycles, WINDOW_CYCLES=256 → result_cnt=63 (saturated); in_range follows thresholds.
- en dropped 100 cycles into COUNT → busy falls next cycle, no result_valid, in_range and channel pointer unchanged; re-enable remeasures the same channel.
- rst pulsed during COUNT with nonzero in_range → all outputs 0, state IDLE; after release with en=1, first result comes from channel 0.
- lo_thresh=70, hi_thresh=60 with count 64 → in_range[ch]=0; stuck toggle (no transitions) → result_cnt=0, flag 0 for lo_thresh≥1.

Source files
------------

// File: rtl/pll_freq_monitor_pkg.sv
// Shared types and constants for the PLL frequency monitor.
package pll_freq_monitor_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Cycles spent flushing edge history after a channel switch
  localparam int SETTLE_CYCLES = 4;

  // Depth of the metastability synchronizer on the toggle inputs
  localparam int SYNC_STAGES = 2;

  // Channel index width; a single channel still gets a 1-bit index
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_freq_monitor_sync_2ff.sv
// Vector synchronizer for toggle signals arriving from foreign clock domains.
module sync_2ff
  import pll_freq_monitor_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // First stage captures the asynchronous input and may go metastable
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q[gi] <= '0;
        else     stage_q[gi] <= d_i;
      end
    end else begin : g_rest
      // Later stages give the first one a full cycle to resolve
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q[gi] <= '0;
        else     stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_freq_monitor.sv
// Round-robin frequency monitor: counts synchronized toggle transitions of
// each PLL channel over a fixed reference window and flags in-range counts.
module pll_freq_monitor
  import pll_freq_monitor_pkg::*;
#(
  parameter int  NUM_CH        = 8,
  parameter int  WINDOW_CYCLES = 1024,
  parameter int  CNT_W         = 16,
  localparam int CH_W          = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] meas_tgl,
  input  logic [CNT_W-1:0]  lo_thresh,
  input  logic [CNT_W-1:0]  hi_thresh,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic [CNT_W-1:0]  result_cnt,
  output logic [NUM_CH-1:0] in_range,
  output logic              busy
);

  localparam int             WIN_W       = $clog2(WINDOW_CYCLES + 1);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);

  state_e             state_q;
  logic [WIN_W-1:0]   win_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CH_W-1:0]    ch_q;
  logic [CH_W-1:0]    ch_d;
  logic               result_valid_q;
  logic [CH_W-1:0]    result_ch_q;
  logic [CNT_W-1:0]   result_cnt_q;
  logic [NUM_CH-1:0]  in_range_q;
  logic [NUM_CH-1:0]  in_range_d;
  logic [NUM_CH-1:0]  tgl_sync;
  logic [NUM_CH-1:0]  tgl_dly_q;
  logic [NUM_CH-1:0]  edge_vec;
  logic [NUM_CH-1:0]  ch_hit;
  logic               edge_sel;
  logic               flag_d;

  sync_2ff #(.WIDTH(NUM_CH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (meas_tgl),
    .q_o (tgl_sync)
  );

  // One extra flop so a transition is seen as sync != previous sync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tgl_dly_q <= '0;
    else     tgl_dly_q <= tgl_sync;
  end

  assign edge_vec = tgl_sync ^ tgl_dly_q;

  // One-hot channel decode drives both edge selection and the flag update
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_hit[gi]     = (ch_q == CH_W'(gi));
    assign in_range_d[gi] = (state_q == REPORT && ch_hit[gi]) ? flag_d : in_range_q[gi];
  end

  assign edge_sel = |(edge_vec & ch_hit);

  // Saturating increment: a runaway clock pins the count rather than wrapping
  assign cnt_d = (edge_sel && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  // Inverted thresholds naturally yield 0 here
  assign flag_d = (cnt_q >= lo_thresh) && (cnt_q <= hi_thresh);

  assign ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

  // Scan FSM with window/edge counters, channel pointer and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      win_q          <= '0;
      cnt_q          <= '0;
      ch_q           <= '0;
      result_valid_q <= 1'b0;
      result_ch_q    <= '0;
      result_cnt_q   <= '0;
      in_range_q     <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          win_q <= '0;
          cnt_q <= '0;
          if (en) state_q <= SETTLE;
        end
        SETTLE: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= '0;
            if (win_q == SETTLE_LAST) begin
              win_q   <= '0;
              state_q <= COUNT;
            end else begin
              win_q <= win_q + 1'b1;
            end
          end
        end
        COUNT: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (win_q == WIN_LAST) begin
              win_q   <= '0;
              state_q <= REPORT;
            end else begin
              win_q <= win_q + 1'b1;
            end
          end
        end
        REPORT: begin
          result_valid_q <= 1'b1;
          result_ch_q    <= ch_q;
          result_cnt_q   <= cnt_q;
          in_range_q     <= in_range_d;
          ch_q           <= ch_d;
          win_q          <= '0;
          state_q        <= en ? SETTLE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign result_ch    = result_ch_q;
  assign result_cnt   = result_cnt_q;
  assign in_range     = in_range_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Directed bench for pll_freq_monitor with a result scoreboard.
module tb_pll_freq_monitor;

  localparam int NCH = 8;
  localparam int WIN = 256;

  typedef struct {
    int           ch;
    int           cnt;
    logic [7:0]   flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  tgl = '0;
  logic [15:0] lo  = 16'd60;
  logic [15:0] hi  = 16'd68;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [15:0] result_cnt;
  logic [7:0]  in_range;
  logic        busy;

  // Saturation instance: 6-bit counter, one channel
  logic        en_s  = 1'b0;
  logic [0:0]  tgl_s = '0;
  logic [5:0]  lo_s  = 6'd60;
  logic [5:0]  hi_s  = 6'd63;
  logic        valid_s;
  logic [0:0]  ch_s;
  logic [5:0]  cnt_s;
  logic [0:0]  range_s;
  logic        busy_s;

  int   errors = 0;
  int   checks = 0;
  int   per[NCH];
  int   tcnt[NCH];
  int   tcnt_s = 0;
  logic [7:0] model_flags = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pll_freq_monitor #(.NUM_CH(NCH), .WINDOW_CYCLES(WIN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .meas_tgl(tgl),
    .lo_thresh(lo), .hi_thresh(hi),
    .result_valid(result_valid), .result_ch(result_ch),
    .result_cnt(result_cnt), .in_range(in_range), .busy(busy)
  );

  pll_freq_monitor #(.NUM_CH(1), .WINDOW_CYCLES(WIN), .CNT_W(6)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .meas_tgl(tgl_s),
    .lo_thresh(lo_s), .hi_thresh(hi_s),
    .result_valid(valid_s), .result_ch(ch_s),
    .result_cnt(cnt_s), .in_range(range_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int cnt);
    exp_t e;
    model_flags[ch] = (cnt >= int'(lo)) && (cnt <= int'(hi));
    e.ch = ch; e.cnt = cnt; e.flags = model_flags;
    sb.push_back(e);
  endtask

  // Waits for result_valid, sampling 1 time unit after each rising edge
  task automatic wait_valid(input int max, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < max) begin
      @(posedge clk); n++; #1;
      if (result_valid) begin ok = 1'b1; break; end
    end
  endtask

  // Toggle generators: channel i flips every per[i] cycles (0 = stuck)
  initial begin
    for (int i = 0; i < NCH; i++) tcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (per[i] != 0) begin
          tcnt[i]++;
          if (tcnt[i] >= per[i]) begin tgl[i] = ~tgl[i]; tcnt[i] = 0; end
        end
      end
      tcnt_s++;
      if (tcnt_s >= 2) begin tgl_s = ~tgl_s; tcnt_s = 0; end
    end
  end

  // Scoreboard monitor: every result pulse must match the next expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("result ch=%0d cnt=%0d in_range=%b", result_ch, result_cnt, in_range);
          check("result_ch", 64'(result_ch), 64'(e.ch));
          check("result_cnt", 64'(result_cnt), 64'(e.cnt));
          check("in_range", 64'(in_range), 64'(e.flags));
        end
      end
    end
  end

  initial begin
    int n;
    bit ok;
    int exp_cnt[NCH];
    per = '{4, 2, 4, 8, 16, 0, 32, 2};
    for (int i = 0; i < NCH; i++) exp_cnt[i] = (per[i] == 0) ? 0 : WIN / per[i];

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_ch", 64'(result_ch), 64'd0);
    check("rst_cnt", 64'(result_cnt), 64'd0);
    check("rst_in_range", 64'(in_range), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);

    // Full scan plus wrap to channel 0
    for (int i = 0; i < NCH; i++) push_exp(i, exp_cnt[i]);
    push_exp(0, exp_cnt[0]);
    en = 1'b1;
    wait_valid(WIN + 40, n, ok);
    check("first_latency", 64'(ok ? n - 1 : -1), 64'(WIN + 5));
    for (int i = 1; i <= NCH; i++) begin
      wait_valid(WIN + 40, n, ok);
      check("scan_period", 64'(ok ? n : -1), 64'(WIN + 5));
    end

    // Abort 100 cycles into COUNT of channel 1
    repeat (SETTLE_WAIT()) @(posedge clk);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    wait_valid(WIN + 40, n, ok);
    check("abort_no_result", 64'(ok), 64'd0);
    check("abort_in_range", 64'(in_range), 64'(model_flags));

    // Re-enable: same channel (1) remeasured, now in range
    per[1] = 4;
    repeat (20) @(negedge clk);
    push_exp(1, WIN / 4);
    en = 1'b1;
    wait_valid(WIN + 40, n, ok);
    check("reenable_latency", 64'(ok ? n - 1 : -1), 64'(WIN + 5));

    // Inverted thresholds force channel 2's flag to 0
    lo = 16'd70; hi = 16'd60;
    push_exp(2, exp_cnt[2]);
    wait_valid(WIN + 40, n, ok);
    check("inv_period", 64'(ok ? n : -1), 64'(WIN + 5));

    // Reset pulsed mid-window of channel 3
    repeat (60) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #2;
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_ch", 64'(result_ch), 64'd0);
    check("midrst_cnt", 64'(result_cnt), 64'd0);
    check("midrst_in_range", 64'(in_range), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sb_empty", 64'(sb.size()), 64'd0);
    model_flags = '0;
    lo = 16'd60; hi = 16'd68;
    @(negedge clk); rst = 1'b0;
    push_exp(0, exp_cnt[0]);
    wait_valid(WIN + 40, n, ok);
    check("postrst_latency", 64'(ok ? n - 1 : -1), 64'(WIN + 5));
    @(negedge clk); en = 1'b0;
    repeat (5) @(negedge clk);
    check("end_busy", 64'(busy), 64'd0);

    // Saturation: 128 transitions into a 6-bit counter
    en_s = 1'b1;
    n = 0;
    while (n < WIN + 40 && !valid_s) begin @(posedge clk); n++; #1; end
    check("sat_seen", 64'(valid_s), 64'd1);
    $display("sat result ch=%0d cnt=%0d in_range=%b", ch_s, cnt_s, range_s);
    check("sat_cnt", 64'(cnt_s), 64'd63);
    check("sat_ch", 64'(ch_s), 64'd0);
    check("sat_flag_hi", 64'(range_s), 64'd1);
    hi_s = 6'd62;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (n < WIN + 40 && !valid_s);
    $display("sat result ch=%0d cnt=%0d in_range=%b", ch_s, cnt_s, range_s);
    check("sat_period", 64'(n), 64'(WIN + 5));
    check("sat_cnt2", 64'(cnt_s), 64'd63);
    check("sat_flag_lo", 64'(range_s), 64'd0);
    en_s = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // SETTLE plus 100 cycles into the COUNT window
  function automatic int SETTLE_WAIT();
    return 4 + 100;
  endfunction

endmodule
